// File: rtl/heap_ingress_queue_if.sv
// rtl/heap_ingress_queue_if.sv - sketch-side ingress stream, query request and heap-side issue port
interface heap_ingress_queue_if #(
  parameter int CNT_SIZE  = 20,
  parameter int ADDR_SIZE = 28,
  parameter int DEPTH     = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // sketch estimate stream
  logic                 in_valid;
  logic [CNT_SIZE-1:0]  in_cnt;
  logic [ADDR_SIZE-1:0] in_addr;
  logic                 in_ready;

  // heap query arbitration
  logic                 query_req;
  logic                 query_ack;

  // heap input port
  logic                 out_valid;
  logic [CNT_SIZE-1:0]  out_cnt;
  logic [ADDR_SIZE-1:0] out_addr;
  logic                 out_query;

  // status
  logic [LVL_W-1:0]     level;
  logic [15:0]          coalesce_cnt;

  // upstream side: sketch update path plus query requester
  modport master (
    output in_valid, in_cnt, in_addr, query_req,
    input  in_ready, query_ack, out_valid, out_cnt, out_addr, out_query,
    input  level, coalesce_cnt
  );

  // the ingress queue itself
  modport slave (
    input  in_valid, in_cnt, in_addr, query_req,
    output in_ready, query_ack, out_valid, out_cnt, out_addr, out_query,
    output level, coalesce_cnt
  );
endinterface

// File: rtl/heap_ingress_queue.sv
// rtl/heap_ingress_queue.sv - coalescing, gap-paced ingress queue feeding the max-heap
module heap_ingress_queue #(
  parameter int CNT_SIZE  = 20,
  parameter int ADDR_SIZE = 28,
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  heap_ingress_queue_if.slave bus_io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP) + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

  // queue storage: valid bits are reset, payload is not
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [CNT_SIZE-1:0]  cnt_q  [DEPTH];
  logic [CNT_SIZE-1:0]  cnt_d  [DEPTH];
  logic [ADDR_SIZE-1:0] addr_q [DEPTH];
  logic [ADDR_SIZE-1:0] addr_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [LVL_W-1:0]     level_q, level_d;

  // issue engine and heap-facing registers
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_query_q, out_query_d;
  logic [CNT_SIZE-1:0]  out_cnt_q, out_cnt_d;
  logic [ADDR_SIZE-1:0] out_addr_q, out_addr_d;
  logic [15:0]          coal_q, coal_d;

  // per-cycle decisions
  logic                 in_ready;
  logic                 accept;
  logic                 issue_ok;
  logic                 pop;
  logic                 query_fire;
  logic [DEPTH-1:0]     hit;
  logic [PTR_W-1:0]     hit_idx;
  logic                 any_hit;
  logic                 coalesce;
  logic                 push;

  // Readiness looks only at registered occupancy, so a same-cycle pop never opens a slot.
  assign in_ready   = !rst_i && (level_q < LVL_FULL);
  assign accept     = bus_io.in_valid && in_ready;
  assign issue_ok   = (gap_q == '0);
  assign pop        = issue_ok && (level_q != '0);
  // Queries wait for an empty queue so they see every estimate accepted before them.
  assign query_fire = issue_ok && (level_q == '0) && bus_io.query_req;
  assign any_hit    = |hit;
  assign coalesce   = accept && any_hit;
  assign push       = accept && !any_hit;

  // Address match against waiting entries; the head leaving this cycle cannot absorb a beat.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus_io.in_addr) && !(pop && (head_q == PTR_W'(i)))) begin
        hit[i]  = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Queue next state: pop at head, merge into a matching entry, or append at tail.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end

    if (coalesce && (bus_io.in_cnt > cnt_q[hit_idx])) begin
      cnt_d[hit_idx] = bus_io.in_cnt;
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      cnt_d[tail_q]   = bus_io.in_cnt;
      addr_d[tail_q]  = bus_io.in_addr;
      tail_d          = tail_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Issue engine: register the popped head or a query pulse, then hold off for the gap.
  always_comb begin
    out_valid_d = pop;
    out_query_d = query_fire;
    out_cnt_d   = out_cnt_q;
    out_addr_d  = out_addr_q;
    gap_d       = gap_q;
    coal_d      = coal_q;

    if (pop) begin
      out_cnt_d  = cnt_q[head_q];
      out_addr_d = addr_q[head_q];
    end

    if (pop || query_fire) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_ONE;
    end

    if (coalesce && (coal_q != 16'hFFFF)) begin
      coal_d = coal_q + 16'd1;
    end
  end

  // Control and output registers, cleared by reset so no partial pulse escapes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_query_q <= 1'b0;
      out_cnt_q   <= '0;
      out_addr_q  <= '0;
      coal_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_query_q <= out_query_d;
      out_cnt_q   <= out_cnt_d;
      out_addr_q  <= out_addr_d;
      coal_q      <= coal_d;
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    cnt_q  <= cnt_d;
    addr_q <= addr_d;
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.out_valid    = out_valid_q;
  assign bus_io.out_cnt      = out_cnt_q;
  assign bus_io.out_addr     = out_addr_q;
  assign bus_io.out_query    = out_query_q;
  assign bus_io.query_ack    = out_query_q;
  assign bus_io.level        = level_q;
  assign bus_io.coalesce_cnt = coal_q;
endmodule

// File: tb/tb_heap_ingress_queue.sv
// tb/tb_heap_ingress_queue.sv - directed and randomized bench for heap_ingress_queue with a queue-level model
module tb_heap_ingress_queue;
  localparam int CNT_SIZE  = 20;
  localparam int ADDR_SIZE = 28;
  localparam int DEPTH     = 8;
  localparam int ISSUE_GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  heap_ingress_queue_if #(.CNT_SIZE(CNT_SIZE), .ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH)) bus ();

  heap_ingress_queue #(
    .CNT_SIZE (CNT_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .DEPTH    (DEPTH),
    .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  typedef struct {
    logic [CNT_SIZE-1:0]  cnt;
    logic [ADDR_SIZE-1:0] addr;
  } ent_t;

  // reference model: the queue as an ordered list of (cnt, addr)
  ent_t                 mq[$];
  int                   m_gap  = 0;
  bit                   m_ov   = 1'b0;
  bit                   m_oq   = 1'b0;
  logic [CNT_SIZE-1:0]  m_oc   = '0;
  logic [ADDR_SIZE-1:0] m_oa   = '0;
  int                   m_coal = 0;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_step(input bit v, input logic [CNT_SIZE-1:0] c,
                            input logic [ADDR_SIZE-1:0] a, input bit q, input bit r);
    bit   acc;
    bit   do_pop;
    bit   do_query;
    int   k;
    ent_t head;
    ent_t e;
    if (r) begin
      mq.delete();
      m_gap  = 0;
      m_ov   = 1'b0;
      m_oq   = 1'b0;
      m_oc   = '0;
      m_oa   = '0;
      m_coal = 0;
    end else begin
      acc      = v && (mq.size() < DEPTH);
      do_pop   = (m_gap == 0) && (mq.size() > 0);
      do_query = (m_gap == 0) && (mq.size() == 0) && q;
      m_ov     = do_pop;
      m_oq     = do_query;
      if (do_pop) begin
        head = mq.pop_front();
        m_oc = head.cnt;
        m_oa = head.addr;
      end
      if (acc) begin
        k = -1;
        foreach (mq[i]) if (mq[i].addr == a) k = i;
        if (k >= 0) begin
          if (c > mq[k].cnt) mq[k].cnt = c;
          if (m_coal < 65535) m_coal++;
        end else begin
          e.cnt  = c;
          e.addr = a;
          mq.push_back(e);
        end
      end
      if (do_pop || do_query) m_gap = ISSUE_GAP - 1;
      else if (m_gap > 0) m_gap--;
    end
  endtask

  task automatic compare_all();
    chk("out_valid",    64'(bus.out_valid),    64'(m_ov));
    chk("out_cnt",      64'(bus.out_cnt),      64'(m_oc));
    chk("out_addr",     64'(bus.out_addr),     64'(m_oa));
    chk("out_query",    64'(bus.out_query),    64'(m_oq));
    chk("query_ack",    64'(bus.query_ack),    64'(m_oq));
    chk("level",        64'(bus.level),        64'(mq.size()));
    chk("coalesce_cnt", 64'(bus.coalesce_cnt), 64'(m_coal));
    chk("in_ready",     64'(bus.in_ready),     64'(!rst && (mq.size() < DEPTH)));
  endtask

  // drive at the falling edge, step the model, check after the next rising edge
  task automatic cycle(input bit v, input logic [CNT_SIZE-1:0] c,
                       input logic [ADDR_SIZE-1:0] a, input bit q, input bit r);
    bus.in_valid  = v;
    bus.in_cnt    = c;
    bus.in_addr   = a;
    bus.query_req = q;
    rst           = r;
    model_step(v, c, a, q, r);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  int t2_cnt  [3] = '{6, 11, 5};
  int t2_addr [3] = '{106, 111, 105};

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

  initial begin
    int                   pulse_t[$];
    int                   pulse_c[$];
    int                   k;
    int                   n108;
    int                   c108;
    bit                   first_ready;
    bit                   rdy;
    logic [ADDR_SIZE-1:0] last_a;
    bit                   qreq;
    int                   nv;
    int                   last_v;
    int                   ack_t;
    int                   nack;
    int                   pool;
    bit                   v;
    bit                   r;

    bus.in_valid  = 1'b0;
    bus.in_cnt    = '0;
    bus.in_addr   = '0;
    bus.query_req = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    compare_all();

    // reset held, then first cycle out of reset
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("ready_after_reset", 64'(bus.in_ready), 64'(1));

    // single beat on an idle queue: issued one edge after acceptance
    cycle(1'b1, CNT_SIZE'(7), ADDR_SIZE'(107), 1'b0, 1'b0);
    chk("t1_accept_level", 64'(bus.level), 64'(1));
    chk("t1_not_bypassed", 64'(bus.out_valid), 64'(0));
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t1_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t1_out_cnt",   64'(bus.out_cnt),   64'(7));
    chk("t1_out_addr",  64'(bus.out_addr),  64'(107));
    chk("t1_level",     64'(bus.level),     64'(0));
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t1_hold_cnt",  64'(bus.out_cnt),   64'(7));

    // three back-to-back beats issue exactly ISSUE_GAP apart, in order
    idle(3);
    for (int i = 0; i < 12; i++) begin
      if (i < 3) cycle(1'b1, CNT_SIZE'(t2_cnt[i]), ADDR_SIZE'(t2_addr[i]), 1'b0, 1'b0);
      else       cycle(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t2_in_ready", 64'(bus.in_ready), 64'(1));
      if (bus.out_valid) begin
        pulse_t.push_back(i);
        pulse_c.push_back(int'(bus.out_cnt));
      end
    end
    chk("t2_pulses", 64'(pulse_t.size()), 64'(3));
    if (pulse_t.size() == 3) begin
      chk("t2_spacing_a", 64'(pulse_t[1] - pulse_t[0]), 64'(ISSUE_GAP));
      chk("t2_spacing_b", 64'(pulse_t[2] - pulse_t[1]), 64'(ISSUE_GAP));
      chk("t2_order_0",   64'(pulse_c[0]), 64'(6));
      chk("t2_order_1",   64'(pulse_c[1]), 64'(11));
      chk("t2_order_2",   64'(pulse_c[2]), 64'(5));
    end

    // coalesce: 108 stays queued behind other entries while two repeats arrive
    do_reset();
    cycle(1'b1, CNT_SIZE'(1),  ADDR_SIZE'(201), 1'b0, 1'b0);
    cycle(1'b1, CNT_SIZE'(2),  ADDR_SIZE'(202), 1'b0, 1'b0);
    cycle(1'b1, CNT_SIZE'(3),  ADDR_SIZE'(203), 1'b0, 1'b0);
    cycle(1'b1, CNT_SIZE'(8),  ADDR_SIZE'(108), 1'b0, 1'b0);
    cycle(1'b1, CNT_SIZE'(3),  ADDR_SIZE'(108), 1'b0, 1'b0);
    cycle(1'b1, CNT_SIZE'(10), ADDR_SIZE'(108), 1'b0, 1'b0);
    n108 = 0;
    c108 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      if (bus.out_valid && (bus.out_addr == ADDR_SIZE'(108))) begin
        n108++;
        c108 = int'(bus.out_cnt);
      end
    end
    chk("coal_issues", 64'(n108), 64'(1));
    chk("coal_merged_cnt", 64'(c108), 64'(10));
    chk("coal_count", 64'(bus.coalesce_cnt), 64'(2));

    // full queue: ninth beat is held until a slot opens, order preserved
    do_reset();
    k = 0;
    while ((bus.level != ($clog2(DEPTH) + 1)'(DEPTH)) && (k < 60)) begin
      cycle(1'b1, CNT_SIZE'(k), ADDR_SIZE'(300 + k), 1'b0, 1'b0);
      k++;
    end
    chk("full_level", 64'(bus.level), 64'(DEPTH));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    first_ready = bus.in_ready;
    rdy = 1'b0;
    for (int j = 0; (j < 20) && !rdy; j++) begin
      rdy = bus.in_ready;
      cycle(1'b1, CNT_SIZE'(17), ADDR_SIZE'(117), 1'b0, 1'b0);
    end
    chk("full_ninth_held", 64'(first_ready), 64'(0));
    chk("full_ninth_accepted", 64'(rdy), 64'(1));
    last_a = '0;
    for (int j = 0; j < 30; j++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      if (bus.out_valid) last_a = bus.out_addr;
    end
    chk("full_last_issued", 64'(last_a), 64'(117));

    // query waits for the queue to drain, then pulses once after the gap
    do_reset();
    cycle(1'b1, CNT_SIZE'(41), ADDR_SIZE'(401), 1'b0, 1'b0);
    qreq   = 1'b1;
    nv     = 0;
    last_v = -1;
    ack_t  = -1;
    nack   = 0;
    for (int s = 0; s < 20; s++) begin
      if (s == 0) cycle(1'b1, CNT_SIZE'(42), ADDR_SIZE'(402), qreq, 1'b0);
      else        cycle(1'b0, '0, '0, qreq, 1'b0);
      if (bus.out_valid) begin
        if (ack_t < 0) nv++;
        last_v = s;
      end
      if (bus.query_ack) begin
        nack++;
        ack_t = s;
        qreq  = 1'b0;
      end
    end
    chk("query_pulses", 64'(nack), 64'(1));
    chk("query_after_entries", 64'(nv), 64'(2));
    chk("query_gap", 64'(ack_t - last_v), 64'(ISSUE_GAP));

    // reset mid-stream with four entries queued and one merge recorded
    do_reset();
    k = 0;
    while ((bus.level != ($clog2(DEPTH) + 1)'(4)) && (k < 30)) begin
      cycle(1'b1, CNT_SIZE'(k), ADDR_SIZE'(501 + k), 1'b0, 1'b0);
      k++;
    end
    chk("mid_level_before", 64'(bus.level), 64'(4));
    cycle(1'b1, CNT_SIZE'(900), ADDR_SIZE'(501 + k - 1), 1'b0, 1'b0);
    chk("mid_coal_before", 64'(bus.coalesce_cnt), 64'(1));
    cycle(1'b1, CNT_SIZE'(5), ADDR_SIZE'(777), 1'b0, 1'b1);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_level", 64'(bus.level), 64'(0));
    chk("mid_rst_coal",  64'(bus.coalesce_cnt), 64'(0));
    for (int j = 0; j < 5; j++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      chk("mid_no_valid_after", 64'(bus.out_valid), 64'(0));
    end

    // randomized traffic alternating narrow (merge-heavy) and wide address pools
    qreq = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      pool = ((i / 250) % 2 == 0) ? 4 : 24;
      if (!qreq && ($urandom_range(0, 19) == 0)) qreq = 1'b1;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 299) == 0);
      cycle(v, CNT_SIZE'($urandom), ADDR_SIZE'(1000 + $urandom_range(0, pool - 1)), qreq, r);
      if (bus.query_ack || r) qreq = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/heap_ingress_queue.md
# heap_ingress_queue

Ingress buffer between the count-min sketch update path and the max-heap. It accepts (count, address) estimates at sketch rate, absorbs repeats of an address still waiting in the queue by keeping the larger count, and issues entries to the heap's `input_valid`/`input_cnt`/`input_addr` port. The heap needs a minimum spacing between accepted inputs, so issues are paced by a programmable gap. Heap query requests are arbitrated onto `input_query` whenever the queue is drained.

## Interface
- `CNT_SIZE`, 20: count width.
- `ADDR_SIZE`, 28: address width.
- `DEPTH`, 8: queue entries; power of 2, ≥2.
- `ISSUE_GAP`, 2: minimum number of cycles from one heap issue to the next (≥1); 1 allows back-to-back issues.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sketch estimate valid.
- `in_cnt` in CNT_SIZE: estimated count.
- `in_addr` in ADDR_SIZE: address.
- `in_ready` out 1: a beat is accepted when `in_valid & in_ready`.
- `query_req` in 1: level request for a heap query; held until acknowledged.
- `query_ack` out 1: one-cycle pulse, coincident with `out_query`.
- `out_valid` out 1: drives heap `input_valid`; one-cycle pulse per entry.
- `out_cnt` out CNT_SIZE: drives heap `input_cnt`.
- `out_addr` out ADDR_SIZE: drives heap `input_addr`.
- `out_query` out 1: drives heap `input_query`; one-cycle pulse.
- `level` out $clog2(DEPTH)+1: number of occupied entries.
- `coalesce_cnt` out 16: saturating count of merged beats.

## Operation
- Storage is a circular FIFO with per-entry valid, cnt and addr; head and tail pointers wrap modulo DEPTH.
- `in_ready` = !rst && level < DEPTH. It is registered-state based, so a pop in the same cycle does not open a slot.
- Coalesce:
  - On an accepted beat, `in_addr` is compared against every valid entry, excluding the entry being popped this cycle.
  - On a hit, the matching entry's cnt becomes max(stored, in_cnt), level is unchanged and `coalesce_cnt` increments (saturating at 0xFFFF).
  - At most one entry can match, because the queue never holds duplicate addresses.
  - If the only match is the entry being popped, the beat is enqueued as a new entry at the tail.
- Otherwise the beat is written at the tail and level increments.
- Issue engine uses `gap_cnt`, width $clog2(ISSUE_GAP)+1:
  - Issue is allowed when gap_cnt == 0.
  - Priority 1: if level > 0, the head is popped and registered onto `out_*` with `out_valid`=1 for one cycle.
  - Priority 2: if level == 0 and `query_req`, assert `out_query` and `query_ack` for one cycle.
  - Any issue loads gap_cnt with ISSUE_GAP-1; otherwise gap_cnt decrements toward 0.
- `out_cnt`/`out_addr` hold their last issued value while `out_valid`=0.
- A query is never issued while entries are pending, so it observes every estimate accepted before it.
- Simultaneous push and pop: both take effect and level is unchanged. A coalesce hit combined with a pop decrements level by 1.

## Timing
- Reset values, and values while `rst`=1: `out_valid`=0, `out_query`=0, `query_ack`=0, `out_cnt`=0, `out_addr`=0, `level`=0, `coalesce_cnt`=0, `in_ready`=0, gap_cnt=0, all entries invalid.
- `in_ready`=1 from the first cycle after `rst` deasserts.
- Latency: a beat accepted at edge t into an empty queue with gap_cnt==0 is visible on `out_*` after edge t+1. The beat is not bypassed in the same cycle.
- Steady throughput is one issue per ISSUE_GAP cycles.
- A coalesced update to an entry takes effect at the next edge. If that entry is popped at the following edge, it issues with the merged count.
- Reset asserted mid-operation discards all queued entries and any pending gap at the next edge. No partial pulse is produced.

## Test plan
- Reset, then push 7/107 on an idle queue → `out_valid` at the cycle after acceptance, with `out_cnt`=7 and `out_addr`=107; `level` returns to 0.
- ISSUE_GAP=2: push 6/106, 11/111, 5/105 back-to-back → three `out_valid` pulses exactly two cycles apart, in order; `in_ready` stays 1.
- Coalesce: push 8/108, then 3/108, then 10/108 while the entry is still queued (hold issue with a large ISSUE_GAP) → one issue of 10/108; `coalesce_cnt`=2.
- Full: ISSUE_GAP=16, push 8 distinct addresses → `level`=8 and `in_ready`=0. The 9th beat (17/117) is held until the first pop, then accepted; order is preserved.
- Query: assert `query_req` with 2 entries queued → both entries issue first, then `out_query`/`query_ack` pulse once, respecting the gap.
- Reset mid-stream with 4 entries queued → no `out_valid` after the reset edge; `level`=0 and `coalesce_cnt`=0.
